// File: rtl/mem_stage_pkg.sv
// Shared widths, load-control bit indices and the EX->MEM payload layout for the memory stage.
package mem_stage_pkg;

  localparam int EXREG_W  = 141;
  localparam int MEMREG_W = 70;
  localparam int BYP_W    = 38;

  // ld_ctrl is one-hot: {ld_w, ld_hu, ld_h, ld_bu, ld_b}
  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

  typedef struct packed {
    logic        mul;
    logic [31:0] mul_result;
    logic [31:0] ex_result;
    logic [31:0] rkd_value;
    logic [4:0]  ld_ctrl;
    logic        rf_we;
    logic        res_from_mem;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
  } ex_bus_t;

endpackage

// File: rtl/mem_ld_align.sv
// Load data extraction: picks the addressed byte/half/word from the read word and extends it.
module mem_ld_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [1:0]  off,
  input  logic [4:0]  ld_ctrl,
  output logic [31:0] load_val
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (off)
      2'd0:    byte_v = rword[7:0];
      2'd1:    byte_v = rword[15:8];
      2'd2:    byte_v = rword[23:16];
      default: byte_v = rword[31:24];
    endcase
    half_v = off[1] ? rword[31:16] : rword[15:0];
  end

  // An all-zero ld_ctrl on a load is illegal upstream; it simply yields zero.
  always_comb begin
    load_val = 32'h0;
    if (ld_ctrl[LD_W])       load_val = rword;
    else if (ld_ctrl[LD_HU]) load_val = {16'h0, half_v};
    else if (ld_ctrl[LD_H])  load_val = {{16{half_v[15]}}, half_v};
    else if (ld_ctrl[LD_BU]) load_val = {24'h0, byte_v};
    else if (ld_ctrl[LD_B])  load_val = {{24{byte_v[7]}}, byte_v};
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX->MEM register, SRAM read-data hold buffer, load alignment,
// result select, and the bypass/WB buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                EXreg_valid,
  input  logic                EX_ready_go,
  input  logic [EXREG_W-1:0]  EXreg_bus,
  output logic                MEM_allow_in,
  input  logic                WB_allow_in,
  input  logic [31:0]         data_sram_rdata,
  output logic [BYP_W-1:0]    MEM_bypass_bus,
  output logic                MEMreg_valid,
  output logic [MEMREG_W-1:0] MEMreg_bus
);

  // Handshake: an instruction moves EX->MEM when EXreg_valid & EX_ready_go & MEM_allow_in,
  // and leaves MEM when mem_valid & mem_ready_go & WB_allow_in; neither side may retract valid.
  logic        mem_ready_go;
  logic        mem_valid;
  logic        first_cyc;
  logic        rbuf_valid;
  logic [31:0] rbuf;
  ex_bus_t     ex_in;
  ex_bus_t     ex_q;
  logic        ex_accept;
  logic        mem_leave;
  logic [31:0] rword;
  logic [31:0] load_val;
  logic [31:0] result;
  logic        rf_we_out;
  logic        unused_ok;

  assign mem_ready_go = 1'b1;
  assign ex_in        = ex_bus_t'(EXreg_bus);
  assign MEM_allow_in = ~mem_valid | (mem_ready_go & WB_allow_in);
  assign ex_accept    = EXreg_valid & EX_ready_go & MEM_allow_in;
  assign mem_leave    = mem_valid & mem_ready_go & WB_allow_in;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      first_cyc <= 1'b0;
      ex_q      <= '0;
    end else begin
      if (MEM_allow_in) mem_valid <= EXreg_valid & EX_ready_go;
      if (ex_accept)    ex_q      <= ex_in;
      first_cyc <= ex_accept & ex_in.res_from_mem;
    end
  end

  // SRAM rdata is only valid in a load's first MEM cycle; hold it if WB stalls us then.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rbuf_valid <= 1'b0;
      rbuf       <= 32'h0;
    end else if (mem_valid & first_cyc & ex_q.res_from_mem & ~WB_allow_in) begin
      rbuf_valid <= 1'b1;
      rbuf       <= data_sram_rdata;
    end else if (mem_leave) begin
      rbuf_valid <= 1'b0;
    end
  end

  assign rword = rbuf_valid ? rbuf : data_sram_rdata;

  mem_ld_align u_ld_align (
    .rword    (rword),
    .off      (ex_q.ex_result[1:0]),
    .ld_ctrl  (ex_q.ld_ctrl),
    .load_val (load_val)
  );

  always_comb begin
    result = ex_q.ex_result;
    if (ex_q.res_from_mem) result = load_val;
    else if (ex_q.mul)     result = ex_q.mul_result;
  end

  assign rf_we_out      = ex_q.rf_we & mem_valid;
  assign MEMreg_valid   = mem_valid;
  assign MEMreg_bus     = {rf_we_out, ex_q.rf_waddr, result, ex_q.pc};
  assign MEM_bypass_bus = {ex_q.rf_waddr, rf_we_out, result};

  // Store data is consumed by EX when issuing the SRAM write, not here.
  assign unused_ok = ^ex_q.rkd_value;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads of each width, WB stall hold, mul select, EX stall, reset mid-stall.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                clk;
  logic                resetn;
  logic                EXreg_valid;
  logic                EX_ready_go;
  logic [EXREG_W-1:0]  EXreg_bus;
  logic                MEM_allow_in;
  logic                WB_allow_in;
  logic [31:0]         data_sram_rdata;
  logic [BYP_W-1:0]    MEM_bypass_bus;
  logic                MEMreg_valid;
  logic [MEMREG_W-1:0] MEMreg_bus;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .EXreg_valid     (EXreg_valid),
    .EX_ready_go     (EX_ready_go),
    .EXreg_bus       (EXreg_bus),
    .MEM_allow_in    (MEM_allow_in),
    .WB_allow_in     (WB_allow_in),
    .data_sram_rdata (data_sram_rdata),
    .MEM_bypass_bus  (MEM_bypass_bus),
    .MEMreg_valid    (MEMreg_valid),
    .MEMreg_bus      (MEMreg_bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_pc;
  logic        byp_we;
  logic [4:0]  byp_waddr;
  logic [31:0] byp_res;
  assign wb_we     = MEMreg_bus[69];
  assign wb_waddr  = MEMreg_bus[68:64];
  assign wb_wdata  = MEMreg_bus[63:32];
  assign wb_pc     = MEMreg_bus[31:0];
  assign byp_waddr = MEM_bypass_bus[37:33];
  assign byp_we    = MEM_bypass_bus[32];
  assign byp_res   = MEM_bypass_bus[31:0];

  function automatic logic [EXREG_W-1:0] make_bus(input logic mul, input logic [31:0] mul_res,
      input logic [31:0] ex_res, input logic [4:0] ld_ctrl, input logic rf_we,
      input logic res_from_mem, input logic [4:0] waddr, input logic [31:0] pc);
    ex_bus_t b;
    b.mul = mul; b.mul_result = mul_res; b.ex_result = ex_res; b.rkd_value = 32'hA5A5_5A5A;
    b.ld_ctrl = ld_ctrl; b.rf_we = rf_we; b.res_from_mem = res_from_mem;
    b.rf_waddr = waddr; b.pc = pc;
    return b;
  endfunction

  // driver tasks: inputs change 1ns after the rising edge, outputs are checked on the falling edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_ex(input logic v, input logic rg, input logic [EXREG_W-1:0] bus);
    EXreg_valid = v; EX_ready_go = rg; EXreg_bus = bus;
  endtask

  task automatic test_reset();
    resetn = 1'b0; drive_ex(1'b0, 1'b1, '0); WB_allow_in = 1'b1; data_sram_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (MEMreg_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", MEMreg_valid); else pass_cnt++;
    total_cnt++; if (byp_we !== 1'b0) $display("FAIL rst_byp_we: got %b want 0", byp_we); else pass_cnt++;
    total_cnt++; if (MEM_allow_in !== 1'b1) $display("FAIL rst_allow_in: got %b want 1", MEM_allow_in); else pass_cnt++;
    total_cnt++; if (MEMreg_bus !== '0) $display("FAIL rst_bus: got %h want 0", MEMreg_bus); else pass_cnt++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_load_byte();
    drive_ex(1'b1, 1'b1, make_bus(1'b0, 32'h0, 32'h0000_1003, 5'b00001, 1'b1, 1'b1, 5'd7, 32'h1C00_0010));
    tick();
    drive_ex(1'b0, 1'b1, '0); data_sram_rdata = 32'h80FF_1234;
    mid();
    total_cnt++; if (MEMreg_valid !== 1'b1) $display("FAIL ldb_valid: got %b want 1", MEMreg_valid); else pass_cnt++;
    total_cnt++; if (wb_wdata !== 32'hFFFF_FF80) $display("FAIL ldb_wdata: got %h want ffffff80", wb_wdata); else pass_cnt++;
    total_cnt++; if (byp_we !== 1'b1) $display("FAIL ldb_byp_we: got %b want 1", byp_we); else pass_cnt++;
    total_cnt++; if (byp_res !== 32'hFFFF_FF80) $display("FAIL ldb_byp_res: got %h want ffffff80", byp_res); else pass_cnt++;
    total_cnt++; if ({wb_we, wb_waddr, byp_waddr} !== {1'b1, 5'd7, 5'd7}) $display("FAIL ldb_waddr: got %b/%0d/%0d want 1/7/7", wb_we, wb_waddr, byp_waddr); else pass_cnt++;
    total_cnt++; if (wb_pc !== 32'h1C00_0010) $display("FAIL ldb_pc: got %h want 1c000010", wb_pc); else pass_cnt++;
    tick();
    mid();
    total_cnt++; if ({MEMreg_valid, byp_we, wb_we} !== 3'b000) $display("FAIL ldb_bubble: got %b want 000", {MEMreg_valid, byp_we, wb_we}); else pass_cnt++;
    tick();
  endtask

  // back-to-back loads, no stall: each reads live rdata in its single MEM cycle
  task automatic test_back_to_back();
    logic [4:0]  ctrl [4] = '{5'b01000, 5'b00100, 5'b00010, 5'b00001};
    logic [1:0]  offs [4] = '{2'd2, 2'd2, 2'd2, 2'd1};
    logic [31:0] rdat [4] = '{32'hBEEF_0001, 32'hBEEF_0001, 32'h80FF_1234, 32'h80FF_1234};
    logic [31:0] expv [4] = '{32'h0000_BEEF, 32'hFFFF_BEEF, 32'h0000_00FF, 32'h0000_0012};
    drive_ex(1'b1, 1'b1, make_bus(1'b0, 32'h0, {30'h400, offs[0]}, ctrl[0], 1'b1, 1'b1, 5'd3, 32'h100));
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_ex(1'b1, 1'b1, make_bus(1'b0, 32'h0, {30'h400, offs[i+1]}, ctrl[i+1], 1'b1, 1'b1, 5'(4 + i), 32'h104 + 32'(4 * i)));
      else drive_ex(1'b0, 1'b1, '0);
      data_sram_rdata = rdat[i];
      mid();
      total_cnt++; if ({MEMreg_valid, wb_wdata} !== {1'b1, expv[i]}) $display("FAIL b2b_load%0d: got v=%b %h want v=1 %h", i, MEMreg_valid, wb_wdata, expv[i]); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_wb_stall();
    drive_ex(1'b1, 1'b1, make_bus(1'b0, 32'h0, 32'h0000_2000, 5'b10000, 1'b1, 1'b1, 5'd9, 32'h200));
    tick();
    drive_ex(1'b1, 1'b1, make_bus(1'b0, 32'h0, 32'h0000_0077, 5'b00000, 1'b1, 1'b0, 5'd10, 32'h204));
    data_sram_rdata = 32'h1122_3344; WB_allow_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mid();
      total_cnt++; if (wb_wdata !== 32'h1122_3344) $display("FAIL stall_wdata%0d: got %h want 11223344", c, wb_wdata); else pass_cnt++;
      total_cnt++; if ({MEM_allow_in, MEMreg_valid} !== 2'b01) $display("FAIL stall_allow%0d: got allow=%b valid=%b want 0/1", c, MEM_allow_in, MEMreg_valid); else pass_cnt++;
      tick();
      data_sram_rdata = 32'hDEAD_BEEF;
    end
    WB_allow_in = 1'b1;
    mid();
    total_cnt++; if ({MEM_allow_in, wb_wdata} !== {1'b1, 32'h1122_3344}) $display("FAIL stall_release: got allow=%b %h want 1 11223344", MEM_allow_in, wb_wdata); else pass_cnt++;
    tick();
    drive_ex(1'b0, 1'b1, '0);
    mid();
    total_cnt++; if ({MEMreg_valid, wb_waddr, wb_wdata} !== {1'b1, 5'd10, 32'h77}) $display("FAIL stall_next: got v=%b a=%0d %h want v=1 a=10 77", MEMreg_valid, wb_waddr, wb_wdata); else pass_cnt++;
    tick();
  endtask

  task automatic test_mul();
    drive_ex(1'b1, 1'b1, make_bus(1'b1, 32'h6, 32'h5, 5'b00000, 1'b1, 1'b0, 5'd12, 32'h300));
    tick();
    drive_ex(1'b1, 1'b1, make_bus(1'b0, 32'h6, 32'h5, 5'b00000, 1'b1, 1'b0, 5'd13, 32'h304));
    mid();
    total_cnt++; if (wb_wdata !== 32'h6) $display("FAIL mul_sel: got %h want 6", wb_wdata); else pass_cnt++;
    tick();
    drive_ex(1'b0, 1'b1, '0);
    mid();
    total_cnt++; if (wb_wdata !== 32'h5) $display("FAIL alu_sel: got %h want 5", wb_wdata); else pass_cnt++;
    tick();
  endtask

  task automatic test_ex_stall();
    drive_ex(1'b1, 1'b0, make_bus(1'b0, 32'h0, 32'h99, 5'b00000, 1'b1, 1'b0, 5'd14, 32'h400));
    for (int c = 0; c < 2; c++) begin
      tick();
      mid();
      total_cnt++; if ({MEMreg_valid, byp_we} !== 2'b00) $display("FAIL div_bubble%0d: got v=%b we=%b want 0/0", c, MEMreg_valid, byp_we); else pass_cnt++;
    end
    @(posedge clk); #1;
    EX_ready_go = 1'b1;
    tick();
    drive_ex(1'b0, 1'b1, '0);
    mid();
    total_cnt++; if ({MEMreg_valid, byp_we, byp_res} !== {2'b11, 32'h99}) $display("FAIL div_pass: got v=%b we=%b %h want 1/1 99", MEMreg_valid, byp_we, byp_res); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive_ex(1'b1, 1'b1, make_bus(1'b0, 32'h0, 32'h0000_3000, 5'b10000, 1'b1, 1'b1, 5'd15, 32'h500));
    tick();
    drive_ex(1'b0, 1'b1, '0); data_sram_rdata = 32'hAAAA_5555; WB_allow_in = 1'b0;
    tick();
    data_sram_rdata = 32'h1234_5678;
    mid();
    total_cnt++; if (wb_wdata !== 32'hAAAA_5555) $display("FAIL rms_hold: got %h want aaaa5555", wb_wdata); else pass_cnt++;
    #1;
    resetn = 1'b0;
    #1;
    total_cnt++; if ({MEMreg_valid, MEM_allow_in, byp_we} !== 3'b010) $display("FAIL rms_async: got v=%b allow=%b we=%b want 0/1/0", MEMreg_valid, MEM_allow_in, byp_we); else pass_cnt++;
    tick();
    WB_allow_in = 1'b1;
    drive_ex(1'b1, 1'b1, make_bus(1'b0, 32'h0, 32'h0000_3004, 5'b10000, 1'b1, 1'b1, 5'd16, 32'h504));
    mid();
    resetn = 1'b1;
    tick();
    drive_ex(1'b0, 1'b1, '0); data_sram_rdata = 32'hCAFE_F00D;
    mid();
    total_cnt++; if ({MEMreg_valid, wb_wdata} !== {1'b1, 32'hCAFE_F00D}) $display("FAIL rms_live: got v=%b %h want v=1 cafef00d", MEMreg_valid, wb_wdata); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_back_to_back();
    test_wb_stall();
    test_mul();
    test_ex_stall();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
